friscv_wb_arbiter: RTL and testbench

FRISCV_WB_ARBITER -- requirements
Module: friscv_wb_arbiter

---
 rtl/friscv_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_friscv_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_wb_arbiter.sv
// friscv_wb_arbiter: register-file write-back arbiter.
// Three writers (ctrl, memfy, alu) compete for one registered register-file
// write port. Base priority is ctrl > memfy > alu, and at most one handshake
// completes per cycle.
// Optional feature: define FRISCV_WB_AGING_EN to promote a requester that has
// waited AGE_MAX cycles ahead of base priority. Without the macro the arbiter
// is pure fixed priority and has no age registers.
// Handshake: a transfer happens on a rising edge where <r>_valid && <r>_ready.
// ready is a function of the valids and the age state only. Requesters hold
// valid and payload stable until they see ready.
module friscv_wb_arbiter #(
   parameter int XLEN    = 32,
   parameter int AGE_MAX = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              srst,
   input  logic              ctrl_valid,
   output logic              ctrl_ready,
   input  logic [4:0]        ctrl_rd_addr,
   input  logic [XLEN-1:0]   ctrl_rd_val,
   input  logic              memfy_valid,
   output logic              memfy_ready,
   input  logic [4:0]        memfy_rd_addr,
   input  logic [XLEN-1:0]   memfy_rd_val,
   input  logic [XLEN/8-1:0] memfy_rd_strb,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [4:0]        alu_rd_addr,
   input  logic [XLEN-1:0]   alu_rd_val,
   input  logic [XLEN/8-1:0] alu_rd_strb,
   output logic              rf_wr,
   output logic [4:0]        rf_addr,
   output logic [XLEN-1:0]   rf_val,
   output logic [XLEN/8-1:0] rf_strb,
   output logic [2:0]        grant
);

   localparam int SW = XLEN / 8;

   // Reject an out-of-range age threshold at elaboration time.
   if (AGE_MAX < 1 || AGE_MAX > 15) begin : g_age_range_bad
      $error("friscv_wb_arbiter: AGE_MAX must be in 1..15");
   end

   logic [2:0]      req;
   logic [2:0]      aged;
   logic [2:0]      sel;
   logic            active;
   logic [4:0]      mux_addr;
   logic [XLEN-1:0] mux_val;
   logic [SW-1:0]   mux_strb;

   assign req    = {alu_valid, memfy_valid, ctrl_valid};
   assign active = aresetn & ~srst;

`ifdef FRISCV_WB_AGING_EN
   localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

   logic [3:0] age [3];

   // A requester is promoted once it has waited AGE_MAX cycles.
   always_comb begin
      aged = 3'b000;
      for (int i = 0; i < 3; i++) begin
         aged[i] = req[i] && (age[i] == AGE_LIM);
      end
   end

   // Age counters: count waiting cycles, clear on grant or idle, saturate.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < 3; i++) age[i] <= 4'd0;
      end else if (srst) begin
         for (int i = 0; i < 3; i++) age[i] <= 4'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!req[i] || sel[i])
               age[i] <= 4'd0;
            else if (age[i] != AGE_LIM)
               age[i] <= age[i] + 4'd1;
         end
      end
   end
`else
   assign aged = 3'b000;
`endif

   // Pick the winner: aged requesters first, each group by ctrl > memfy > alu.
   always_comb begin
      sel = 3'b000;
      if (active) begin
         if      (aged[0]) sel = 3'b001;
         else if (aged[1]) sel = 3'b010;
         else if (aged[2]) sel = 3'b100;
         else if (req[0])  sel = 3'b001;
         else if (req[1])  sel = 3'b010;
         else if (req[2])  sel = 3'b100;
      end
   end

   assign ctrl_ready  = sel[0];
   assign memfy_ready = sel[1];
   assign alu_ready   = sel[2];

   // Route the winner's payload; the control unit always writes full words.
   always_comb begin
      mux_addr = 5'd0;
      mux_val  = '0;
      mux_strb = '0;
      case (sel)
         3'b001: begin mux_addr = ctrl_rd_addr;  mux_val = ctrl_rd_val;  mux_strb = '1;            end
         3'b010: begin mux_addr = memfy_rd_addr; mux_val = memfy_rd_val; mux_strb = memfy_rd_strb; end
         3'b100: begin mux_addr = alu_rd_addr;   mux_val = alu_rd_val;   mux_strb = alu_rd_strb;   end
         default: ;
      endcase
   end

   // Register the accepted transfer; x0 targets and empty strobes are dropped.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rf_wr   <= 1'b0;
         rf_addr <= 5'd0;
         rf_val  <= '0;
         rf_strb <= '0;
         grant   <= 3'b000;
      end else if (srst) begin
         rf_wr   <= 1'b0;
         rf_addr <= 5'd0;
         rf_val  <= '0;
         rf_strb <= '0;
         grant   <= 3'b000;
      end else if (|sel) begin
         rf_wr   <= (mux_addr != 5'd0) && (|mux_strb);
         rf_addr <= mux_addr;
         rf_val  <= mux_val;
         rf_strb <= mux_strb;
         grant   <= sel;
      end else begin
         rf_wr   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_friscv_wb_arbiter.sv
// Bench for friscv_wb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbitration rules.
module tb_friscv_wb_arbiter;
  localparam int XLEN    = 32;
  localparam int SW      = XLEN / 8;
  localparam int AGE_MAX = 4;
  localparam int PW      = 5 + XLEN + SW;

  logic            aclk;
  logic            aresetn;
  logic            srst;
  logic [2:0]      v;
  logic [4:0]      a [3];
  logic [XLEN-1:0] d [3];
  logic [SW-1:0]   s [3];
  logic            ctrl_ready, memfy_ready, alu_ready;
  logic            rf_wr;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_val;
  logic [SW-1:0]   rf_strb;
  logic [2:0]      grant;

  friscv_wb_arbiter #(.XLEN(XLEN), .AGE_MAX(AGE_MAX)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .ctrl_valid(v[0]), .ctrl_ready(ctrl_ready),
    .ctrl_rd_addr(a[0]), .ctrl_rd_val(d[0]),
    .memfy_valid(v[1]), .memfy_ready(memfy_ready),
    .memfy_rd_addr(a[1]), .memfy_rd_val(d[1]), .memfy_rd_strb(s[1]),
    .alu_valid(v[2]), .alu_ready(alu_ready),
    .alu_rd_addr(a[2]), .alu_rd_val(d[2]), .alu_rd_strb(s[2]),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_val(rf_val), .rf_strb(rf_strb),
    .grant(grant)
  );

  // clock/reset block
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state
  int              wait_cnt [3];
  logic [2:0]      taken;
  logic            exp_wr;
  logic [2:0]      exp_grant;
  logic [PW-1:0]   exp_q [$];
  logic [2:0]      exp_rdy;
  logic [SW-1:0]   st;
  logic [PW-1:0]   got;
  int              pick;

  initial begin
    for (int r = 0; r < 3; r++) wait_cnt[r] = 0;
    taken     = 3'b000;
    exp_wr    = 1'b0;
    exp_grant = 3'b000;
  end

  // Scoreboard: on each falling edge compare outputs with the model, then
  // advance the model across the coming rising edge (inputs are stable here).
  always @(negedge aclk) begin
    exp_rdy = 3'b000;
    pick = -1;
    if (aresetn && !srst) begin
`ifdef FRISCV_WB_AGING_EN
      for (int r = 0; r < 3; r++)
        if (pick < 0 && v[r] && wait_cnt[r] >= AGE_MAX) pick = r;
`endif
      for (int r = 0; r < 3; r++)
        if (pick < 0 && v[r]) pick = r;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
    end
    chk("ready", {alu_ready, memfy_ready, ctrl_ready}, exp_rdy);
    chk("rf_wr", rf_wr, exp_wr);
    if (rf_wr && exp_wr && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("rf_payload", {rf_addr, rf_val, rf_strb}, got);
    end
    chk("grant", grant, exp_grant);

    if (!aresetn || srst) begin
      exp_wr    = 1'b0;
      exp_grant = 3'b000;
      taken     = 3'b000;
      for (int r = 0; r < 3; r++) wait_cnt[r] = 0;
    end else begin
      taken  = exp_rdy;
      exp_wr = 1'b0;
      if (pick >= 0) begin
        exp_grant = exp_rdy;
        st = (pick == 0) ? {SW{1'b1}} : s[pick];
        if (a[pick] != 5'd0 && st != '0) begin
          exp_wr = 1'b1;
          exp_q.push_back({a[pick], d[pick], st});
        end
      end
      for (int r = 0; r < 3; r++) begin
        if (!v[r] || r == pick) wait_cnt[r] = 0;
        else if (wait_cnt[r] < AGE_MAX) wait_cnt[r] = wait_cnt[r] + 1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
    for (int r = 0; r < 3; r++) if (taken[r]) v[r] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input int r, input logic [4:0] ad, input logic [XLEN-1:0] dv,
                     input logic [SW-1:0] sb);
    v[r] = 1'b1;
    a[r] = ad;
    d[r] = dv;
    s[r] = sb;
  endtask

  task automatic put_rand(input int r);
    logic [4:0]    ad;
    logic [SW-1:0] sb;
    if ($urandom_range(0, 9) == 0)      ad = 5'd0;
    else if ($urandom_range(0, 1) == 1) ad = 5'($urandom_range(1, 3));
    else                                ad = 5'($urandom_range(1, 31));
    sb = ($urandom_range(0, 9) == 0) ? '0 : SW'($urandom_range(1, 15));
    put(r, ad, $urandom, sb);
  endtask

  initial begin
    aresetn = 1'b0;
    srst    = 1'b0;
    v       = 3'b000;
    for (int r = 0; r < 3; r++) begin a[r] = 5'd0; d[r] = '0; s[r] = '0; end
    // requests pending during async reset must see no ready
    put(0, 5'd1, 32'h0000_0001, 4'hf);
    put(1, 5'd2, 32'h0000_0002, 4'hf);
    put(2, 5'd6, 32'h0000_0006, 4'hf);
    @(negedge aclk);
    chk("rst_ready", {alu_ready, memfy_ready, ctrl_ready}, 3'b000);
    chk("rst_rf_wr", rf_wr, 1'b0);
    chk("rst_rf_addr", rf_addr, 5'd0);
    chk("rst_rf_val", rf_val, 32'd0);
    chk("rst_rf_strb", rf_strb, 4'd0);
    chk("rst_grant", grant, 3'b000);
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_ctrl", {alu_ready, memfy_ready, ctrl_ready}, 3'b001);
    idle(5);

    // all three valid: ctrl, then memfy, then alu on consecutive cycles
    put(0, 5'd3, 32'h1111_1111, 4'hf);
    put(1, 5'd4, 32'h2222_2222, 4'hf);
    put(2, 5'd5, 32'h3333_3333, 4'hf);
    @(negedge aclk);
    chk("all3_c0_ready", {alu_ready, memfy_ready, ctrl_ready}, 3'b001);
    tick();
    @(negedge aclk);
    chk("all3_c1_ready", {alu_ready, memfy_ready, ctrl_ready}, 3'b010);
    chk("all3_c1_addr", {rf_wr, rf_addr}, {1'b1, 5'd3});
    tick();
    @(negedge aclk);
    chk("all3_c2_ready", {alu_ready, memfy_ready, ctrl_ready}, 3'b100);
    chk("all3_c2_addr", {rf_wr, rf_addr}, {1'b1, 5'd4});
    tick();
    @(negedge aclk);
    chk("all3_c3_addr", {rf_wr, rf_addr, grant}, {1'b1, 5'd5, 3'b100});
    idle(3);

    // ctrl streaming against a waiting alu request
    put(0, 5'd1, $urandom, 4'hf);
    put(2, 5'd7, 32'hA5A5_A5A5, 4'hf);
    for (int k = 0; k < 8; k++) begin
      @(negedge aclk);
`ifdef FRISCV_WB_AGING_EN
      if (k < 4)       chk("age_alu_wait", alu_ready, 1'b0);
      else if (k == 4) chk("age_alu_promoted", alu_ready, 1'b1);
      else if (k == 5) chk("age_alu_write", {rf_wr, rf_addr}, {1'b1, 5'd7});
`else
      chk("fixed_alu_starved", alu_ready, 1'b0);
`endif
      tick();
      if (!v[0]) put(0, 5'd1, $urandom, 4'hf);
    end
`ifndef FRISCV_WB_AGING_EN
    @(negedge aclk);
    chk("fixed_ctrl_last", ctrl_ready, 1'b1);
    tick();
    @(negedge aclk);
    chk("fixed_alu_after", alu_ready, 1'b1);
    tick();
    @(negedge aclk);
    chk("fixed_alu_write", {rf_wr, rf_addr}, {1'b1, 5'd7});
`endif
    idle(4);

    // write to x0 is accepted and dropped
    put(2, 5'd0, 32'hDEAD_BEEF, 4'hf);
    @(negedge aclk);
    chk("x0_ready", alu_ready, 1'b1);
    tick();
    @(negedge aclk);
    chk("x0_rf_wr", rf_wr, 1'b0);
    chk("x0_grant", grant, 3'b100);
    idle(2);

    // partial strobe from memfy
    put(1, 5'd9, 32'h1234_5678, 4'b0011);
    @(negedge aclk);
    chk("strb_ready", memfy_ready, 1'b1);
    tick();
    @(negedge aclk);
    chk("strb_write", {rf_wr, rf_addr, rf_val, rf_strb}, {1'b1, 5'd9, 32'h1234_5678, 4'b0011});
    // empty strobe is accepted and dropped
    put(1, 5'd10, 32'hCAFE_0000, 4'b0000);
    @(negedge aclk);
    chk("zstrb_ready", memfy_ready, 1'b1);
    tick();
    @(negedge aclk);
    chk("zstrb_rf_wr", {rf_wr, grant}, {1'b0, 3'b010});
    idle(2);

    // synchronous reset with three requests pending
    put(0, 5'd11, 32'h0B0B_0B0B, 4'hf);
    put(1, 5'd12, 32'h0C0C_0C0C, 4'hf);
    put(2, 5'd13, 32'h0D0D_0D0D, 4'hf);
    srst = 1'b1;
    @(negedge aclk);
    chk("srst_ready", {alu_ready, memfy_ready, ctrl_ready}, 3'b000);
    tick();
    srst = 1'b0;
    @(negedge aclk);
    chk("srst_rf", {rf_wr, rf_addr, rf_val, rf_strb, grant}, {1'b0, 5'd0, 32'd0, 4'd0, 3'b000});
    chk("srst_restart_ctrl", {alu_ready, memfy_ready, ctrl_ready}, 3'b001);
    idle(5);

    // random traffic with occasional synchronous resets
    for (int i = 0; i < 2000; i++) begin
      tick();
      srst = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < 3; r++)
        if (!v[r] && $urandom_range(0, 99) < 45) put_rand(r);
    end
    srst = 1'b0;
    idle(10);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valids_done", v, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
